// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : call_stack_ctrl
// Purpose  : Return-address call-stack controller. Converts CALL/RET requests
//            into push/pop cycles on an attached stack block, pre-checks
//            full/empty, returns popped addresses with a one-cycle valid
//            pulse, reports overflow/underflow and latches a sticky fault
//            when the stack flags an error on an operation that was expected
//            to succeed.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            call_valid, ret_pc  - CALL request and address to push
//            ret_valid           - RET request
//            ready               - idle, a request will be accepted
//            ret_addr(_valid)    - popped return address and its pulse
//            overflow, underflow - rejected CALL / RET pulses
//            fault               - sticky unexpected stack error
//            depth               - mirror of stack occupancy
//            st_*                - master side of the attached stack
// Revision : 1.0 - initial release
// ============================================================================
module call_stack_ctrl #(
   parameter int width      = 32,
   parameter int wordLength = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       call_valid,
   input  logic                       ret_valid,
   input  logic [wordLength-1:0]      ret_pc,
   output logic                       ready,
   output logic                       ret_addr_valid,
   output logic [wordLength-1:0]      ret_addr,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       fault,
   output logic [$clog2(width):0]     depth,
   output logic                       st_push,
   output logic                       st_pop,
   output logic [wordLength-1:0]      st_din,
   input  logic [wordLength-1:0]      st_dout,
   input  logic                       st_empty,
   input  logic                       st_full,
   input  logic                       st_error
);

   localparam int                    DW        = $clog2(width) + 1;
   localparam logic [DW-1:0]         DEPTH_MAX = DW'(width - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      WAIT = 2'd3
   } state_t;

   state_t                 state_q;
   logic [DW-1:0]          depth_q;
   logic [DW-1:0]          depth_inc_d;
   logic [DW-1:0]          depth_dec_d;
   logic [wordLength-1:0]  din_q;
   logic [wordLength-1:0]  ret_addr_q;
   logic                   ret_addr_valid_q;
   logic                   overflow_q;
   logic                   underflow_q;
   logic                   fault_q;
   logic                   push_q;
   logic                   pop_q;
   // High in the IDLE cycle right after a PUSH, when the stack's registered
   // error flag reflects that push.
   logic                   after_push_q;

   assign depth_inc_d = (depth_q == DEPTH_MAX) ? depth_q : depth_q + 1'b1;
   assign depth_dec_d = (depth_q == '0)        ? depth_q : depth_q - 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         depth_q          <= '0;
         din_q            <= '0;
         ret_addr_q       <= '0;
         ret_addr_valid_q <= 1'b0;
         overflow_q       <= 1'b0;
         underflow_q      <= 1'b0;
         fault_q          <= 1'b0;
         push_q           <= 1'b0;
         pop_q            <= 1'b0;
         after_push_q     <= 1'b0;
      end else begin
         ret_addr_valid_q <= 1'b0;
         overflow_q       <= 1'b0;
         underflow_q      <= 1'b0;
         push_q           <= 1'b0;
         pop_q            <= 1'b0;
         after_push_q     <= 1'b0;

         // The stack registers its error flag, so the flag for a push/pop
         // shows up one cycle after the strobe.
         if (st_error && (after_push_q || state_q == WAIT)) begin
            fault_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               // CALL has priority; a simultaneous RET is simply dropped.
               if (call_valid) begin
                  if (st_full) begin
                     overflow_q <= 1'b1;
                  end else begin
                     din_q   <= ret_pc;
                     push_q  <= 1'b1;
                     depth_q <= depth_inc_d;
                     state_q <= PUSH;
                  end
               end else if (ret_valid) begin
                  if (st_empty) begin
                     underflow_q <= 1'b1;
                  end else begin
                     pop_q   <= 1'b1;
                     depth_q <= depth_dec_d;
                     state_q <= POP;
                  end
               end
            end
            PUSH: begin
               after_push_q <= 1'b1;
               state_q      <= IDLE;
            end
            POP: begin
               state_q <= WAIT;
            end
            WAIT: begin
               // Only valid sample of st_dout: the stack zeroes it otherwise.
               ret_addr_q       <= st_dout;
               ret_addr_valid_q <= 1'b1;
               state_q          <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ready must drop with rst itself and rise on the first cycle after it.
   assign ready          = !rst && (state_q == IDLE);
   assign ret_addr_valid = ret_addr_valid_q;
   assign ret_addr       = ret_addr_q;
   assign overflow       = overflow_q;
   assign underflow      = underflow_q;
   assign fault          = fault_q;
   assign depth          = depth_q;
   assign st_push        = push_q;
   assign st_pop         = pop_q;
   assign st_din         = din_q;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_stack_ctrl
// Purpose  : Self-checking bench for call_stack_ctrl. Hosts a behavioural
//            stack block and a transaction-level LIFO reference model; drives
//            directed and random CALL/RET traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_stack_ctrl;

   localparam int W  = 4;
   localparam int WL = 32;
   localparam int DW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          call_valid = 1'b0;
   logic          ret_valid = 1'b0;
   logic [WL-1:0] ret_pc = '0;
   logic          ready;
   logic          ret_addr_valid;
   logic [WL-1:0] ret_addr;
   logic          overflow;
   logic          underflow;
   logic          fault;
   logic [DW-1:0] depth;
   logic          st_push;
   logic          st_pop;
   logic [WL-1:0] st_din;
   logic [WL-1:0] st_dout;
   logic          st_empty;
   logic          st_full;
   logic          st_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   call_stack_ctrl #(.width(W), .wordLength(WL)) dut (
      .clk(clk), .rst(rst), .call_valid(call_valid), .ret_valid(ret_valid),
      .ret_pc(ret_pc), .ready(ready), .ret_addr_valid(ret_addr_valid),
      .ret_addr(ret_addr), .overflow(overflow), .underflow(underflow),
      .fault(fault), .depth(depth), .st_push(st_push), .st_pop(st_pop),
      .st_din(st_din), .st_dout(st_dout), .st_empty(st_empty),
      .st_full(st_full), .st_error(st_error)
   );

   // Behavioural stack block: full at sp == W-1, registered dout/error,
   // dout zeroed on cycles without a pop.
   int            sp = 0;
   logic [WL-1:0] mem [W];
   logic          stk_err;
   logic          force_err = 1'b0;

   assign st_full  = (sp == W - 1);
   assign st_empty = (sp == 0);
   assign st_error = stk_err | force_err;

   always @(posedge clk) begin
      if (rst) begin
         sp      <= 0;
         st_dout <= '0;
         stk_err <= 1'b0;
      end else begin
         stk_err <= 1'b0;
         st_dout <= '0;
         if (st_push) begin
            if (sp == W - 1) stk_err <= 1'b1;
            else begin
               mem[sp] <= st_din;
               sp      <= sp + 1;
            end
         end else if (st_pop) begin
            if (sp == 0) stk_err <= 1'b1;
            else begin
               st_dout <= mem[sp-1];
               sp      <= sp - 1;
            end
         end
      end
   end

   // Reference model: plain LIFO of return addresses.
   logic [WL-1:0] q [$];
   logic [WL-1:0] last_ret  = '0;
   logic          fault_exp = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_call(input logic [WL-1:0] pc, input logic also_ret);
      chk("call_ready", ready, 1);
      call_valid = 1'b1;
      ret_valid  = also_ret;
      ret_pc     = pc;
      step();
      call_valid = 1'b0;
      ret_valid  = 1'b0;
      if (q.size() == W - 1) begin
         chk("ovf_pulse", overflow, 1);
         chk("ovf_nopush", st_push, 0);
         chk("ovf_ready", ready, 1);
         step();
         chk("ovf_end", overflow, 0);
      end else begin
         chk("push_strobe", st_push, 1);
         chk("push_din", st_din, pc);
         chk("push_nopop", st_pop, 0);
         chk("push_busy", ready, 0);
         chk("push_noovf", overflow, 0);
         q.push_back(pc);
         step();
         chk("push_end", st_push, 0);
         chk("push_ready", ready, 1);
      end
      chk("call_novalid", ret_addr_valid, 0);
      chk("call_depth", depth, q.size());
      chk("call_fault", fault, fault_exp);
   endtask

   task automatic do_ret();
      logic [WL-1:0] exp;
      chk("ret_ready", ready, 1);
      ret_valid = 1'b1;
      step();
      ret_valid = 1'b0;
      if (q.size() == 0) begin
         chk("udf_pulse", underflow, 1);
         chk("udf_nopop", st_pop, 0);
         chk("udf_ready", ready, 1);
         chk("udf_hold", ret_addr, last_ret);
         chk("udf_novalid", ret_addr_valid, 0);
         step();
         chk("udf_end", underflow, 0);
      end else begin
         exp = q.pop_back();
         chk("pop_strobe", st_pop, 1);
         chk("pop_nopush", st_push, 0);
         chk("pop_busy", ready, 0);
         chk("pop_novalid", ret_addr_valid, 0);
         step();
         chk("wait_nopop", st_pop, 0);
         chk("wait_busy", ready, 0);
         chk("wait_novalid", ret_addr_valid, 0);
         step();
         chk("ret_valid", ret_addr_valid, 1);
         chk("ret_addr", ret_addr, exp);
         chk("ret_ready_back", ready, 1);
         last_ret = exp;
         step();
         chk("ret_pulse_end", ret_addr_valid, 0);
         chk("ret_addr_hold", ret_addr, exp);
      end
      chk("ret_depth", depth, q.size());
      chk("ret_fault", fault, fault_exp);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step();
      chk("rst_ready", ready, 0);
      step();
      chk("rst_push", st_push, 0);
      chk("rst_pop", st_pop, 0);
      chk("rst_din", st_din, 0);
      chk("rst_addr", ret_addr, 0);
      chk("rst_valid", ret_addr_valid, 0);
      chk("rst_flags", {overflow, underflow, fault}, 0);
      chk("rst_depth", depth, 0);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", ready, 1);
      step();
      chk("post_rst_depth", depth, 0);

      // Fill, overflow, drain, underflow
      do_call(32'h100, 1'b0);
      do_call(32'h200, 1'b0);
      do_call(32'h300, 1'b0);
      chk("full_flag", st_full, 1);
      do_call(32'h400, 1'b0);
      repeat (4) do_ret();
      chk("underflow_hold", ret_addr, 32'h100);

      // CALL and RET together: CALL wins
      do_call(32'hAA0, 1'b0);
      do_call(32'hBB0, 1'b1);
      chk("both_depth", depth, 2);

      // Reset while in WAIT
      ret_valid = 1'b1;
      step();
      ret_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("rstw_valid", ret_addr_valid, 0);
      chk("rstw_depth", depth, 0);
      chk("rstw_pop", st_pop, 0);
      rst = 1'b0;
      #1;
      chk("rstw_ready", ready, 1);
      q.delete();
      last_ret = '0;
      step();
      chk("rstw_valid2", ret_addr_valid, 0);
      chk("rstw_addr", ret_addr, 0);

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         int op;
         op = int'($urandom_range(0, 3));
         if (op <= 1)      do_call($urandom, 1'b0);
         else if (op == 2) do_ret();
         else              do_call($urandom, 1'b1);
         repeat ($urandom_range(0, 2)) begin
            step();
            chk("gap_idle", {st_push, st_pop, ret_addr_valid}, 0);
         end
      end

      // Injected stack error right after a push
      if (q.size() == W - 1) do_ret();
      call_valid = 1'b1;
      ret_pc     = 32'hF00D;
      step();
      call_valid = 1'b0;
      q.push_back(32'hF00D);
      step();
      force_err = 1'b1;
      step();
      force_err = 1'b0;
      fault_exp = 1'b1;
      chk("fault_set", fault, 1);
      do_ret();
      do_call(32'h1234, 1'b0);
      chk("fault_sticky", fault, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("fault_cleared", fault, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
